// File: rtl/state_seq.sv
// Instruction sequencer FSM: FETCH/DECODE/DEREF/LOAD/EXEC/STORE with registered,
// glitch-free strobes. Define STATE_SEQ_HALT_EN to add the halt input and HALT state.
module state_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] ibus,
    input  logic        mem_ack,
`ifdef STATE_SEQ_HALT_EN
    input  logic        halt,
    output logic        halted,
`endif
    output logic        mem_req,
    output logic        mem_we,
    output logic [11:0] ir,
    output logic        nderef,
    output logic        nstate_load,
    output logic        nstate_exec,
    output logic        nwrp,
    output logic        df_wr,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_DEREF  = 3'd2,
        S_LOAD   = 3'd3,
        S_EXEC   = 3'd4,
`ifdef STATE_SEQ_HALT_EN
        S_STORE  = 3'd5,
        S_HALT   = 3'd6
`else
        S_STORE  = 3'd5
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] ir_q, ir_d;
    logic        mem_req_q, mem_we_q, nderef_q, nstate_load_q, nstate_exec_q, nwrp_q, df_wr_q;
    logic        mem_req_d, mem_we_d, nderef_d, nstate_load_d, nstate_exec_d, nwrp_d, df_wr_d;
`ifdef STATE_SEQ_HALT_EN
    logic        halted_q, halted_d;
`endif

    logic [2:0] opcode;
    logic       is_read;
    logic       indirect;
    logic       ack;

    assign opcode   = ir_q[11:9];
    assign is_read  = (opcode <= 3'd3);
    assign indirect = ir_q[8] && (opcode <= 3'd5);
    // An acknowledge only counts while a request is actually on the bus.
    assign ack      = mem_req_q && mem_ack;

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_FETCH: begin
                if (ack) begin
                    ir_d    = ibus;
                    state_d = S_DECODE;
                end
`ifdef STATE_SEQ_HALT_EN
                else if (halt) begin
                    state_d = S_HALT;
                end
`endif
            end
            S_DECODE: begin
                if (indirect)     state_d = S_DEREF;
                else if (is_read) state_d = S_LOAD;
                else              state_d = S_EXEC;
            end
            S_DEREF: begin
                if (ack) state_d = is_read ? S_LOAD : S_EXEC;
            end
            S_LOAD: begin
                if (ack) state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = (opcode == 3'd4) ? S_STORE : S_FETCH;
            end
            S_STORE: begin
                if (ack) state_d = S_FETCH;
            end
`ifdef STATE_SEQ_HALT_EN
            S_HALT: begin
                if (!halt) state_d = S_FETCH;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes are decoded from the next state and registered with it, so each
    // output flop mirrors the state register and never glitches.
    always_comb begin
        mem_req_d     = (state_d == S_FETCH) || (state_d == S_DEREF) ||
                        (state_d == S_LOAD)  || (state_d == S_STORE);
        mem_we_d      = (state_d == S_STORE);
        nderef_d      = (state_d != S_DEREF);
        nstate_load_d = (state_d != S_LOAD);
        nstate_exec_d = (state_d != S_EXEC);
        nwrp_d        = !((state_d == S_EXEC) && (opcode == 3'd5));
        df_wr_d       = (state_d == S_EXEC) && (opcode == 3'd6);
`ifdef STATE_SEQ_HALT_EN
        halted_d      = (state_d == S_HALT);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_FETCH;
            ir_q          <= 12'h000;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            nderef_q      <= 1'b1;
            nstate_load_q <= 1'b1;
            nstate_exec_q <= 1'b1;
            nwrp_q        <= 1'b1;
            df_wr_q       <= 1'b0;
`ifdef STATE_SEQ_HALT_EN
            halted_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            ir_q          <= ir_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            nderef_q      <= nderef_d;
            nstate_load_q <= nstate_load_d;
            nstate_exec_q <= nstate_exec_d;
            nwrp_q        <= nwrp_d;
            df_wr_q       <= df_wr_d;
`ifdef STATE_SEQ_HALT_EN
            halted_q      <= halted_d;
`endif
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign ir          = ir_q;
    assign nderef      = nderef_q;
    assign nstate_load = nstate_load_q;
    assign nstate_exec = nstate_exec_q;
    assign nwrp        = nwrp_q;
    assign df_wr       = df_wr_q;
    assign state_o     = state_q;
`ifdef STATE_SEQ_HALT_EN
    assign halted      = halted_q;
`endif

endmodule

// File: tb/tb_state_seq.sv
// Bench for state_seq: directed instruction scenarios plus random instructions with
// random acknowledge delays, checked cycle by cycle against a phase-list model.
module tb_state_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] ibus = 12'h000;
    logic        mem_ack = 1'b0;
    logic        mem_req, mem_we, nderef, nstate_load, nstate_exec, nwrp, df_wr;
    logic [11:0] ir;
    logic [2:0]  dbg_state;
`ifdef STATE_SEQ_HALT_EN
    logic        halt = 1'b0;
    logic        halted;
`endif

    state_seq dut (
        .clk         (clk),
        .rst         (rst),
        .ibus        (ibus),
        .mem_ack     (mem_ack),
`ifdef STATE_SEQ_HALT_EN
        .halt        (halt),
        .halted      (halted),
`endif
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .ir          (ir),
        .nderef      (nderef),
        .nstate_load (nstate_load),
        .nstate_exec (nstate_exec),
        .nwrp        (nwrp),
        .df_wr       (df_wr),
        .state_o     (dbg_state)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // {mem_req, mem_we, nderef, nstate_load, nstate_exec, nwrp, df_wr}
    localparam logic [6:0] INACTIVE = 7'b0011110;
    logic [6:0] obs;
    assign obs = {mem_req, mem_we, nderef, nstate_load, nstate_exec, nwrp, df_wr};

    typedef enum {P_FETCH, P_DECODE, P_DEREF, P_LOAD, P_EXEC, P_STORE} phase_t;

    logic [11:0] model_ir = 12'h000;
    int n_deref, n_load, n_exec, n_wrp, n_dfwr, n_we, n_cycles;

    function automatic logic [6:0] expect_strobes(phase_t p, logic [2:0] op);
        logic [6:0] e;
        e = INACTIVE;
        case (p)
            P_FETCH: e[6] = 1'b1;
            P_DEREF: begin e[6] = 1'b1; e[4] = 1'b0; end
            P_LOAD:  begin e[6] = 1'b1; e[3] = 1'b0; end
            P_EXEC: begin
                e[2] = 1'b0;
                if (op == 3'd5) e[1] = 1'b0;
                if (op == 3'd6) e[0] = 1'b1;
            end
            P_STORE: begin e[6] = 1'b1; e[5] = 1'b1; end
            default: e = INACTIVE;
        endcase
        return e;
    endfunction

    // Precondition: just after a rising edge with the DUT in an active FETCH.
    task automatic run_instr(input logic [11:0] word, input int store_delay, input int max_delay);
        phase_t      q[$];
        phase_t      p;
        logic [2:0]  op;
        logic [6:0]  exp;
        logic [11:0] exp_ir;
        bit          is_mem;
        int          d;
        op = word[11:9];
        q = {P_FETCH, P_DECODE};
        if (op <= 3'd5 && word[8]) q.push_back(P_DEREF);
        if (op <= 3'd3) q.push_back(P_LOAD);
        q.push_back(P_EXEC);
        if (op == 3'd4) q.push_back(P_STORE);
        n_deref = 0; n_load = 0; n_exec = 0; n_wrp = 0; n_dfwr = 0; n_we = 0; n_cycles = 0;
        foreach (q[i]) begin
            p = q[i];
            is_mem = (p == P_FETCH) || (p == P_DEREF) || (p == P_LOAD) || (p == P_STORE);
            d = 0;
            if (is_mem) d = (p == P_STORE && store_delay >= 0) ? store_delay : $urandom_range(0, max_delay);
            for (int k = 0; k <= d; k++) begin
                mem_ack = is_mem ? (k == d) : 1'($urandom_range(0, 1));
                ibus    = (p == P_FETCH) ? word : 12'($urandom);
`ifdef STATE_SEQ_HALT_EN
                halt    = (p == P_FETCH) ? 1'b0 : 1'($urandom_range(0, 1));
`endif
                @(negedge clk);
                exp    = expect_strobes(p, op);
                exp_ir = (p == P_FETCH) ? model_ir : word;
                vectors++;
                if (obs !== exp) begin
                    miscompares++;
                    $display("FAIL strobes ir=%h phase=%0d cyc=%0d state=%0d: got %b want %b",
                             word, i, n_cycles, dbg_state, obs, exp);
                end
                vectors++;
                if (ir !== exp_ir) begin
                    miscompares++;
                    $display("FAIL ir_reg phase=%0d: got %h want %h", i, ir, exp_ir);
                end
`ifdef STATE_SEQ_HALT_EN
                vectors++;
                if (halted !== 1'b0) begin
                    miscompares++;
                    $display("FAIL halted_idle: got %b want 0", halted);
                end
`endif
                if (!nderef)      n_deref++;
                if (!nstate_load) n_load++;
                if (!nstate_exec) n_exec++;
                if (!nwrp)        n_wrp++;
                if (df_wr)        n_dfwr++;
                if (mem_we)       n_we++;
                n_cycles++;
                @(posedge clk); #1;
            end
        end
        mem_ack = 1'b0;
`ifdef STATE_SEQ_HALT_EN
        halt = 1'b0;
`endif
        model_ir = word;
    endtask

    // Releases reset just after an edge, checks the idle cycle (ack ignored), then
    // checks that the request appears at the next edge.
    task automatic release_reset(input string name);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ack = 1'b1;
        ibus = 12'hFFF;
        @(negedge clk);
        vectors++;
        if (obs !== INACTIVE) begin
            miscompares++;
            $display("FAIL %s_idle: got %b want %b", name, obs, INACTIVE);
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        vectors++;
        if (mem_req !== 1'b1 || ir !== 12'h000) begin
            miscompares++;
            $display("FAIL %s_first_req: got req=%b ir=%h want req=1 ir=000", name, mem_req, ir);
        end
        model_ir = 12'h000;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (obs !== INACTIVE || ir !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_state: got %b ir=%h want %b ir=000", obs, ir, INACTIVE);
        end
        release_reset("reset");
    endtask

    task automatic check_counts(input string name, input int cyc, input int dr, input int ld,
                                input int ex, input int wp, input int dw, input int we);
        vectors++;
        if (n_cycles !== cyc || n_deref !== dr || n_load !== ld || n_exec !== ex ||
            n_wrp !== wp || n_dfwr !== dw || n_we !== we) begin
            miscompares++;
            $display("FAIL %s_counts: got cyc=%0d deref=%0d load=%0d exec=%0d wrp=%0d dfwr=%0d we=%0d want %0d %0d %0d %0d %0d %0d %0d",
                     name, n_cycles, n_deref, n_load, n_exec, n_wrp, n_dfwr, n_we,
                     cyc, dr, ld, ex, wp, dw, we);
        end
    endtask

    task automatic test_read_direct();
        run_instr(12'h000, -1, 0);
        check_counts("read_direct", 4, 0, 1, 1, 0, 0, 0);
    endtask

    task automatic test_read_indirect();
        run_instr(12'h100, -1, 0);
        check_counts("read_indirect", 5, 1, 1, 1, 0, 0, 0);
    endtask

    task automatic test_jump();
        run_instr(12'hA00, -1, 0);
        check_counts("jump", 3, 0, 0, 1, 1, 0, 0);
    endtask

    task automatic test_cdf();
        run_instr(12'hC00, -1, 0);
        check_counts("cdf", 3, 0, 0, 1, 0, 1, 0);
    endtask

    task automatic test_store_delayed();
        run_instr(12'h800, 2, 0);
        check_counts("store_delay", 6, 0, 0, 1, 0, 0, 3);
    endtask

    task automatic test_timing();
        run_instr(12'hE00, -1, 0);
        check_counts("operate", 3, 0, 0, 1, 0, 0, 0);
        run_instr(12'hF00, -1, 0);
        check_counts("operate_ind_bit", 3, 0, 0, 1, 0, 0, 0);
        run_instr(12'h900, -1, 0);
        check_counts("store_indirect", 5, 1, 0, 1, 0, 0, 1);
        run_instr(12'hB00, -1, 0);
        check_counts("jump_indirect", 4, 1, 0, 1, 1, 0, 0);
    endtask

    task automatic test_reset_mid_load();
        logic [11:0] words[2];
        words[0] = 12'h000;
        words[1] = 12'h0AB;
        foreach (words[w]) begin
            ibus = words[w];
            mem_ack = 1'b1;
            @(posedge clk); #1;
            @(posedge clk); #1;
            mem_ack = 1'b0;
            @(negedge clk);
            vectors++;
            if (nstate_load !== 1'b0 || mem_req !== 1'b1 || ir !== words[w]) begin
                miscompares++;
                $display("FAIL rst_mid_load_pre: got nload=%b req=%b ir=%h want 0 1 %h",
                         nstate_load, mem_req, ir, words[w]);
            end
            #2 rst = 1'b1;
            #1;
            vectors++;
            if (obs !== INACTIVE || ir !== 12'h000) begin
                miscompares++;
                $display("FAIL rst_mid_load_async: got %b ir=%h want %b ir=000", obs, ir, INACTIVE);
            end
            mem_ack = 1'b1;
            repeat (2) begin
                @(negedge clk);
                vectors++;
                if (obs !== INACTIVE || ir !== 12'h000) begin
                    miscompares++;
                    $display("FAIL rst_mid_load_hold: got %b ir=%h want %b ir=000", obs, ir, INACTIVE);
                end
            end
            release_reset("rst_mid_load");
            run_instr(12'($urandom), -1, 2);
        end
    endtask

`ifdef STATE_SEQ_HALT_EN
    task automatic test_halt();
        halt = 1'b1;
        mem_ack = 1'b0;
        @(negedge clk);
        vectors++;
        if (mem_req !== 1'b1 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_request: got req=%b halted=%b want 1 0", mem_req, halted);
        end
        @(posedge clk); #1;
        repeat (3) begin
            mem_ack = 1'($urandom_range(0, 1));
            ibus = 12'($urandom);
            @(negedge clk);
            vectors++;
            if (halted !== 1'b1 || obs !== INACTIVE) begin
                miscompares++;
                $display("FAIL halt_hold: got halted=%b strobes=%b want 1 %b", halted, obs, INACTIVE);
            end
            @(posedge clk); #1;
        end
        halt = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);
        vectors++;
        if (halted !== 1'b1) begin
            miscompares++;
            $display("FAIL halt_release_edge: got %b want 1", halted);
        end
        @(posedge clk); #1;
        vectors++;
        if (halted !== 1'b0 || mem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL halt_resume: got halted=%b req=%b want 0 1", halted, mem_req);
        end
        run_instr(12'h100, -1, 0);
        check_counts("after_halt", 5, 1, 1, 1, 0, 0, 0);
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 40; n++) run_instr(12'($urandom), -1, 3);
    endtask

    initial begin
        test_reset();
        test_read_direct();
        test_read_indirect();
        test_jump();
        test_cdf();
        test_store_delayed();
        test_timing();
        test_reset_mid_load();
`ifdef STATE_SEQ_HALT_EN
        test_halt();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
